// File: rtl/flash_uart_pkg.sv
// Shared opcodes, reply bytes, status codes and FSM states for the UART flash
// programmer/reader family.
package flash_uart_pkg;

  localparam logic [7:0] CMD_READ         = 8'h03;
  localparam logic [7:0] CMD_WRITE_ENABLE = 8'h06;
  localparam logic [7:0] CMD_PAGE_PROGRAM = 8'h02;
  localparam logic [7:0] CMD_READ_STATUS  = 8'h05;

  localparam logic [7:0] REPLY_ACK = 8'hDC;
  localparam logic [7:0] REPLY_ERR = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_READ = 3'd2,
    ST_ERR  = 3'd3,
    ST_DONE = 3'd4
  } status_e;

  typedef enum logic [4:0] {
    IDLE, H1, H2, H3,
    CS_SETUP, SEND_CMD, SEND_A2, SEND_A1, SEND_A0,
    READ_BYTE, TX_BYTE, TX_WAIT,
    CS_HIGH, ACK_TX, ACK_WAIT, ACK_HOLD,
    ERR_TX, ERR_WAIT
  } state_e;

endpackage

// File: rtl/spi_byte_xfer.sv
// One SPI mode-0 byte exchange, MSB first: CLK_DIV clk cycles per SCLK half
// period, 16*CLK_DIV cycles per byte; done pulses with the final falling edge.
module spi_byte_xfer #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  output logic [7:0] rx_byte_o,
  output logic       done_o,
  output logic       spi_clk_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i
);
  import flash_uart_pkg::*;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             act_q, act_d;
  logic             sclk_q, sclk_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rx_q, rx_d;

  always_comb begin
    act_d  = act_q;
    sclk_d = sclk_q;
    done_d = 1'b0;
    div_d  = div_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    rx_d   = rx_q;
    if (!act_q) begin
      if (start_i) begin
        act_d  = 1'b1;
        sh_d   = tx_byte_i;
        div_d  = '0;
        bit_d  = '0;
        sclk_d = 1'b0;
      end
    end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_d = '0;
      if (!sclk_q) begin
        // MISO was launched on the previous falling edge, so it is stable here
        sclk_d = 1'b1;
        rx_d   = {rx_q[6:0], spi_miso_i};
      end else begin
        sclk_d = 1'b0;
        if (bit_q == 3'd7) begin
          act_d  = 1'b0;
          done_d = 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
          sh_d  = {sh_q[6:0], 1'b0};
        end
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q  <= 1'b0;
      sclk_q <= 1'b0;
      done_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      rx_q   <= '0;
    end else begin
      act_q  <= act_d;
      sclk_q <= sclk_d;
      done_q <= done_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      rx_q   <= rx_d;
    end
  end

  assign rx_byte_o  = rx_q;
  assign done_o     = done_q;
  assign spi_clk_o  = sclk_q;
  assign spi_mosi_o = sh_q[7];

endmodule

// File: rtl/flash_reader_uart.sv
// Host read-back: takes a 4-byte UART header (addr[23:0], len), streams that many
// flash bytes out over UART via READ DATA, then replies ACK (or ERR on timeout).
module flash_reader_uart #(
  parameter int CLK_DIV    = 2,
  parameter int RX_TIMEOUT = 1000000,
  parameter int CS_IDLE    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic       busy,
  output logic [2:0] status
);
  import flash_uart_pkg::*;

  localparam int CNT_W = $clog2(RX_TIMEOUT + CLK_DIV + 1);
  localparam int IDL_W = $clog2(CS_IDLE + 2);

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDL_W-1:0] idle_q, idle_d;
  logic [8:0]       rem_q, rem_d;
  logic             seen_q, seen_d;
  logic             cs_n_q, cs_n_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             xs_q, xs_d;
  logic [7:0]       xtx_q, xtx_d;
  logic [23:0]      addr_q, addr_d;
  logic [7:0]       rd_byte;
  logic             xdone;

  spi_byte_xfer #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk        (clk),
    .rst        (rst),
    .start_i    (xs_q),
    .tx_byte_i  (xtx_q),
    .rx_byte_o  (rd_byte),
    .done_o     (xdone),
    .spi_clk_o  (spi_clk),
    .spi_mosi_o (spi_mosi),
    .spi_miso_i (spi_miso)
  );

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    cnt_d      = cnt_q;
    idle_d     = (idle_q < IDL_W'(CS_IDLE)) ? idle_q + 1'b1 : idle_q;
    rem_d      = rem_q;
    seen_d     = seen_q;
    cs_n_d     = cs_n_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    xs_d       = 1'b0;
    xtx_d      = xtx_q;
    addr_d     = addr_q;
    unique case (state_q)
      IDLE: if (rx_valid) begin
        addr_d[23:16] = rx_data;
        cnt_d         = '0;
        status_d      = ST_HDR;
        state_d       = H1;
      end
      H1, H2, H3: begin
        // A byte arriving on the timeout cycle still counts
        if (rx_valid) begin
          cnt_d = '0;
          case (state_q)
            H1:      begin addr_d[15:8] = rx_data; state_d = H2; end
            H2:      begin addr_d[7:0]  = rx_data; state_d = H3; end
            default: begin
              rem_d    = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
              cs_n_d   = 1'b0;
              status_d = ST_READ;
              state_d  = CS_SETUP;
            end
          endcase
        end else if (cnt_q == CNT_W'(RX_TIMEOUT - 1)) begin
          status_d = ST_ERR;
          state_d  = ERR_TX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CS_SETUP: if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
        xs_d    = 1'b1;
        xtx_d   = CMD_READ;
        state_d = SEND_CMD;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      SEND_CMD: if (xdone) begin xs_d = 1'b1; xtx_d = addr_q[23:16]; state_d = SEND_A2; end
      SEND_A2:  if (xdone) begin xs_d = 1'b1; xtx_d = addr_q[15:8];  state_d = SEND_A1; end
      SEND_A1:  if (xdone) begin xs_d = 1'b1; xtx_d = addr_q[7:0];   state_d = SEND_A0; end
      SEND_A0:  if (xdone) begin xs_d = 1'b1; xtx_d = 8'h00;         state_d = READ_BYTE; end
      READ_BYTE: if (xdone) state_d = TX_BYTE;
      TX_BYTE: if (!tx_busy) begin
        tx_start_d = 1'b1;
        tx_data_d  = rd_byte;
        rem_d      = rem_q - 9'd1;
        seen_d     = 1'b0;
        state_d    = TX_WAIT;
      end
      TX_WAIT: begin
        // CS stays low here; the flash continues the sequential READ on the next byte
        if (!seen_q) begin
          if (tx_busy) seen_d = 1'b1;
        end else if (!tx_busy) begin
          if (rem_q != 9'd0) begin
            xs_d    = 1'b1;
            xtx_d   = 8'h00;
            state_d = READ_BYTE;
          end else begin
            state_d = CS_HIGH;
          end
        end
      end
      CS_HIGH: begin
        cs_n_d  = 1'b1;
        idle_d  = '0;
        state_d = ACK_TX;
      end
      ACK_TX: if (!tx_busy) begin
        tx_start_d = 1'b1;
        tx_data_d  = REPLY_ACK;
        status_d   = ST_DONE;
        seen_d     = 1'b0;
        state_d    = ACK_WAIT;
      end
      ACK_WAIT: if (!seen_q) begin
        if (tx_busy) seen_d = 1'b1;
      end else if (!tx_busy) begin
        state_d = ACK_HOLD;
      end
      ACK_HOLD: if (idle_q >= IDL_W'(CS_IDLE)) state_d = IDLE;
      ERR_TX: begin
        cs_n_d = 1'b1;
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = REPLY_ERR;
          seen_d     = 1'b0;
          state_d    = ERR_WAIT;
        end
      end
      ERR_WAIT: if (!seen_q) begin
        if (tx_busy) seen_d = 1'b1;
      end else if (!tx_busy) begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      status_q   <= ST_IDLE;
      cnt_q      <= '0;
      idle_q     <= '0;
      rem_q      <= '0;
      seen_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      xs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      rem_q      <= rem_d;
      seen_q     <= seen_d;
      cs_n_q     <= cs_n_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      xs_q       <= xs_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    xtx_q  <= xtx_d;
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign spi_cs_n = cs_n_q;
  assign busy     = (state_q != IDLE);
  assign status   = status_q;

endmodule

// File: tb/tb_flash_reader_uart.sv
// Directed bench for flash_reader_uart with a behavioural SPI flash and UART tx model.
module tb_flash_reader_uart;

  localparam int CLK_DIV    = 2;
  localparam int RX_TIMEOUT = 300;
  localparam int CS_IDLE    = 4;
  localparam int TX_CYC     = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       spi_clk, spi_mosi, spi_cs_n;
  logic       spi_miso = 1'b0;
  logic       busy;
  logic [2:0] status;

  int n_cmp = 0;
  int n_bad = 0;

  flash_reader_uart #(.CLK_DIV(CLK_DIV), .RX_TIMEOUT(RX_TIMEOUT), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n),
    .busy(busy), .status(status)
  );

  always #5 clk = ~clk;

  // UART transmitter: busy for TX_CYC cycles per byte, or held by stall
  logic [7:0] txq[$];
  int         busy_cnt = 0;
  logic       stall = 1'b0;
  assign tx_busy = (busy_cnt != 0) || stall;
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (tx_start) begin
      txq.push_back(tx_data);
      busy_cnt <= TX_CYC;
    end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // SPI flash: 32 bits of cmd+addr in, then sequential data out (22-bit wrap)
  int          fbits = 0;
  logic [31:0] fcmd = '0;
  int          cs_rise = 0, cs_fall = 0;

  function automatic logic [7:0] fmem(input logic [23:0] a);
    case (a)
      24'h000100: return 8'hA5;
      24'h000101: return 8'h5A;
      24'h000102: return 8'h01;
      24'h000103: return 8'hFF;
      24'h3FFFFE: return 8'h3C;
      24'h3FFFFF: return 8'hC3;
      24'h000000: return 8'h11;
      24'h000001: return 8'h22;
      default:    return a[7:0] ^ a[15:8] ^ 8'h6B;
    endcase
  endfunction

  always @(posedge spi_clk) if (!spi_cs_n) begin
    if (fbits < 32) fcmd = {fcmd[30:0], spi_mosi};
    fbits++;
  end
  always @(negedge spi_clk) if (!spi_cs_n && fbits >= 32) begin
    int k;
    logic [23:0] a;
    logic [7:0]  b;
    k = fbits - 32;
    a = (fcmd[23:0] + 24'(k / 8)) & 24'h3FFFFF;
    b = fmem(a);
    spi_miso = b[7 - (k % 8)];
  end
  always @(posedge spi_cs_n) begin fbits = 0; cs_rise++; end
  always @(negedge spi_cs_n) cs_fall++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin @(negedge clk); n++; end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_txn(input string tag, input int cnt, input int bound);
    int n = 0;
    while (txq.size() < cnt && n < bound) begin @(negedge clk); n++; end
    check({tag, "_txn"}, 32'(txq.size()), 32'(cnt));
  endtask

  task automatic clear_obs();
    txq.delete();
    cs_rise = 0;
    cs_fall = 0;
  endtask

  initial begin
    int errs, clk_hi, cs_hi;

    repeat (3) @(negedge clk);
    check("rst_cs_n",   32'(spi_cs_n), 32'd1);
    check("rst_sclk",   32'(spi_clk),  32'd0);
    check("rst_mosi",   32'(spi_mosi), 32'd0);
    check("rst_txs",    32'(tx_start), 32'd0);
    check("rst_txd",    32'(tx_data),  32'd0);
    check("rst_busy",   32'(busy),     32'd0);
    check("rst_status", 32'(status),   32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic 4-byte read
    clear_obs();
    send_hdr(8'h00, 8'h01, 8'h00, 8'h04);
    wait_idle("basic", 3000);
    check("basic_mosi", fcmd, 32'h03000100);
    check("basic_n",    32'(txq.size()), 32'd5);
    if (txq.size() == 5) begin
      check("basic_b0",  32'(txq[0]), 32'hA5);
      check("basic_b1",  32'(txq[1]), 32'h5A);
      check("basic_b2",  32'(txq[2]), 32'h01);
      check("basic_b3",  32'(txq[3]), 32'hFF);
      check("basic_ack", 32'(txq[4]), 32'hDC);
    end
    check("basic_status", 32'(status), 32'd4);
    check("basic_rise",   32'(cs_rise), 32'd1);
    check("basic_fall",   32'(cs_fall), 32'd1);
    check("basic_cs_n",   32'(spi_cs_n), 32'd1);

    // len=0 means 256 bytes
    clear_obs();
    send_hdr(8'h00, 8'h10, 8'h00, 8'h00);
    wait_idle("len256", 30000);
    check("len256_n", 32'(txq.size()), 32'd257);
    errs = 0;
    for (int i = 0; i < 256 && i < txq.size(); i++)
      if (txq[i] !== (8'(i) ^ 8'h7B)) errs++;
    check("len256_data", 32'(errs), 32'd0);
    if (txq.size() == 257) check("len256_ack", 32'(txq[256]), 32'hDC);
    check("len256_mosi", fcmd, 32'h03001000);

    // Flash-internal wrap past 0x3FFFFF
    clear_obs();
    send_hdr(8'h3F, 8'hFF, 8'hFE, 8'h04);
    wait_idle("wrap", 3000);
    check("wrap_mosi", fcmd, 32'h033FFFFE);
    check("wrap_n", 32'(txq.size()), 32'd5);
    if (txq.size() == 5) begin
      check("wrap_b0",  32'(txq[0]), 32'h3C);
      check("wrap_b1",  32'(txq[1]), 32'hC3);
      check("wrap_b2",  32'(txq[2]), 32'h11);
      check("wrap_b3",  32'(txq[3]), 32'h22);
      check("wrap_ack", 32'(txq[4]), 32'hDC);
    end

    // Header timeout after two bytes
    clear_obs();
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (RX_TIMEOUT - 30) @(negedge clk);
    check("to_early_n",    32'(txq.size()), 32'd0);
    check("to_early_busy", 32'(busy), 32'd1);
    wait_idle("to", 2000);
    check("to_n", 32'(txq.size()), 32'd1);
    if (txq.size() == 1) check("to_err", 32'(txq[0]), 32'hFF);
    check("to_status", 32'(status), 32'd3);
    check("to_fall",   32'(cs_fall), 32'd0);
    clear_obs();
    send_hdr(8'h00, 8'h01, 8'h00, 8'h02);
    wait_idle("after_to", 3000);
    check("after_to_n", 32'(txq.size()), 32'd3);
    if (txq.size() == 3) begin
      check("after_to_b0",  32'(txq[0]), 32'hA5);
      check("after_to_b1",  32'(txq[1]), 32'h5A);
      check("after_to_ack", 32'(txq[2]), 32'hDC);
    end

    // UART stall after first byte of a 3-byte read
    clear_obs();
    send_hdr(8'h00, 8'h01, 8'h00, 8'h03);
    wait_txn("stall", 1, 3000);
    stall  = 1'b1;
    clk_hi = 0;
    cs_hi  = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (spi_clk)  clk_hi++;
      if (spi_cs_n) cs_hi++;
    end
    stall = 1'b0;
    check("stall_sclk_hi", 32'(clk_hi), 32'd0);
    check("stall_cs_hi",   32'(cs_hi),  32'd0);
    wait_idle("stall", 3000);
    check("stall_n", 32'(txq.size()), 32'd4);
    if (txq.size() == 4) begin
      check("stall_b0",  32'(txq[0]), 32'hA5);
      check("stall_b1",  32'(txq[1]), 32'h5A);
      check("stall_b2",  32'(txq[2]), 32'h01);
      check("stall_ack", 32'(txq[3]), 32'hDC);
    end

    // Reset while the second data byte is being read
    clear_obs();
    send_hdr(8'h00, 8'h01, 8'h00, 8'h04);
    wait_txn("mrst", 1, 3000);
    begin
      int n = 0;
      while (!spi_clk && n < 500) begin @(negedge clk); n++; end
      check("mrst_in_read", 32'(spi_clk), 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_cs_n", 32'(spi_cs_n), 32'd1);
    check("mrst_txs",  32'(tx_start), 32'd0);
    check("mrst_busy", 32'(busy),     32'd0);
    check("mrst_sclk", 32'(spi_clk),  32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("mrst_no_ack", 32'(txq.size()), 32'd1);
    check("mrst_status", 32'(status), 32'd0);
    clear_obs();
    send_hdr(8'h00, 8'h01, 8'h02, 8'h01);
    wait_idle("after_rst", 3000);
    check("after_rst_n", 32'(txq.size()), 32'd2);
    if (txq.size() == 2) begin
      check("after_rst_b0",  32'(txq[0]), 32'h01);
      check("after_rst_ack", 32'(txq[1]), 32'hDC);
    end
    check("after_rst_status", 32'(status), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
